// File: rtl/blinking_light_pkg.sv
// blinking_light_pkg: filter state encoding, default timing constants and level helper
package blinking_light_pkg;
  typedef enum logic [1:0] {
    S_LO = 2'd0,
    W_HI = 2'd1,
    S_HI = 2'd2,
    W_LO = 2'd3
  } filter_state_t;
  localparam int DEBOUNCE_CYCLES_DEF = 16;
  localparam int LONG_CYCLES_DEF = 64;
  // accepted level: the output only flips once a wait window completes
  function automatic logic is_high(filter_state_t s);
    return s == S_HI || s == W_LO;
  endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: 2-FF synchroniser plus counter-based debounce FSM with registered rise pulse
module debounce_filter
  import blinking_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          raw,
  output filter_state_t state,
  output logic          rise
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic sync1;
  logic sync2;
  logic [CW-1:0] cnt;
  // bring the asynchronous raw input into the clock domain
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end
  // accept a level change only after DEBOUNCE_CYCLES consecutive agreeing samples
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_LO;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      case (state)
        S_LO: if (sync2) begin
          state <= W_HI;
          cnt   <= CW'(1);
        end
        S_HI: if (!sync2) begin
          state <= W_LO;
          cnt   <= CW'(1);
        end
        W_HI: if (!sync2) state <= S_LO;
          else if (cnt == LAST) begin
            state <= S_HI;
            rise  <= 1'b1;
          end else cnt <= cnt + CW'(1);
        W_LO: if (sync2) state <= S_HI;
          else if (cnt == LAST) state <= S_LO;
          else cnt <= cnt + CW'(1);
      endcase
    end
  end
endmodule

// File: rtl/blinking_light_input_conditioner.sv
// blinking_light_input_conditioner: debounced start pulse and en level; LONG_PRESS_EN adds a long-press pulse
module blinking_light_input_conditioner
  import blinking_light_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start_btn,
  input  logic en_sw,
  output logic start,
  output logic en,
  output logic long_press
);
  filter_state_t s_state;
  filter_state_t e_state;
  logic s_rise;
  logic e_rise;
  logic unused_ok;
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
    .clk   (clk),
    .reset (reset),
    .raw   (start_btn),
    .state (s_state),
    .rise  (s_rise)
  );
  debounce_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_en (
    .clk   (clk),
    .reset (reset),
    .raw   (en_sw),
    .state (e_state),
    .rise  (e_rise)
  );
  // register the outputs so the controller sees clean, glitch-free signals
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start <= 1'b0;
      en    <= 1'b0;
    end else begin
      start <= s_rise;
      en    <= is_high(e_state);
    end
  end
`ifdef LONG_PRESS_EN
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  logic [HW-1:0] hold;
  assign unused_ok = e_rise;
  // saturating hold counter; pulse on the edge it reaches LONG_CYCLES, so once per press
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold       <= '0;
      long_press <= 1'b0;
    end else begin
      hold       <= (s_state != S_HI) ? '0 : (hold == HOLD_MAX) ? hold : hold + HW'(1);
      long_press <= s_state == S_HI && hold == HOLD_MAX - HW'(1);
    end
  end
`else
  assign unused_ok  = ^{e_rise, s_state, LONG_CYCLES > 0};
  assign long_press = 1'b0;
`endif
endmodule

// File: tb/tb_blinking_light_input_conditioner.sv
// tb_blinking_light_input_conditioner: directed and random checks against a run-length debounce model
module tb_blinking_light_input_conditioner;
  localparam int DC = 4;
  localparam int LC = 10;
`ifdef LONG_PRESS_EN
  localparam int EXP_LONG = 1;
  localparam int EXP_LONG_AT = 16;
`else
  localparam int EXP_LONG = 0;
  localparam int EXP_LONG_AT = -1;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_btn = 1'b0;
  logic en_sw = 1'b0;
  logic start;
  logic en;
  logic long_press;
  int checks = 0;
  int errors = 0;

  blinking_light_input_conditioner #(.DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .en_sw      (en_sw),
    .start      (start),
    .en         (en),
    .long_press (long_press)
  );

  always #5 clk = ~clk;

  // model: a level flips once the synchronised input has disagreed with it for DC straight cycles
  logic [1:0] m_s1 = '0;
  logic [1:0] m_s2 = '0;
  logic [1:0] m_lvl = '0;
  int m_run[2] = '{0, 0};
  logic m_rise = 1'b0;
  logic m_start = 1'b0;
  logic m_en = 1'b0;
  logic m_long = 1'b0;
`ifdef LONG_PRESS_EN
  int m_hold = 0;
`endif
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_s1 <= '0;
      m_s2 <= '0;
      m_lvl <= '0;
      m_run[0] <= 0;
      m_run[1] <= 0;
      m_rise <= 1'b0;
      m_start <= 1'b0;
      m_en <= 1'b0;
      m_long <= 1'b0;
`ifdef LONG_PRESS_EN
      m_hold <= 0;
`endif
    end else begin
      m_s1 <= {en_sw, start_btn};
      m_s2 <= m_s1;
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_lvl[i]) m_run[i] <= 0;
        else if (m_run[i] == DC - 1) begin
          m_lvl[i] <= ~m_lvl[i];
          m_run[i] <= 0;
        end else m_run[i] <= m_run[i] + 1;
      end
      m_rise <= m_s2[0] && !m_lvl[0] && m_run[0] == DC - 1;
      m_start <= m_rise;
      m_en <= m_lvl[1];
`ifdef LONG_PRESS_EN
      m_hold <= (m_lvl[0] && m_run[0] == 0) ? ((m_hold < LC) ? m_hold + 1 : LC) : 0;
      m_long <= m_lvl[0] && m_run[0] == 0 && m_hold == LC - 1;
`endif
    end
  end

  task automatic idle(input int n);
    start_btn = 1'b0;
    en_sw = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    int first = -1;
    int pulses = 0;
    #2 reset = 1'b0;
    start_btn = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({start, en, long_press} !== 3'b000) begin
      errors++;
      $display("FAIL reset_state: got %b expected 000", {start, en, long_press});
    end
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL reset_release edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (pulses !== 1 || first !== 7) begin
      errors++;
      $display("FAIL reset_held_btn: %0d pulses first at %0d, expected 1 at 7", pulses, first);
    end
    idle(12);
  endtask

  task automatic test_clean_press;
    int first = -1;
    int pulses = 0;
    start_btn = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL clean_press edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    checks++;
    if (pulses !== 1 || first !== 7) begin
      errors++;
      $display("FAIL clean_press_latency: %0d pulses first at %0d, expected 1 at 7", pulses, first);
    end
    idle(12);
  endtask

  task automatic test_bounce;
    logic [6:0] pat = 7'b0111011;
    int pulses = 0;
    int en_hi = 0;
    for (int c = 0; c < 21; c++) begin
      start_btn = (c < 7) ? pat[c] : 1'b0;
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL bounce edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start || long_press) pulses++;
      if (en) en_hi++;
    end
    checks++;
    if (pulses !== 0 || en_hi !== 0) begin
      errors++;
      $display("FAIL bounce_reject: %0d pulses %0d en-high cycles, expected 0 and 0", pulses, en_hi);
    end
    idle(12);
  endtask

  task automatic test_en;
    int rise_at = -1;
    int fall_at = -1;
    int changes = 0;
    logic prev = 1'b0;
    en_sw = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL en edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (en !== prev) begin
        changes++;
        if (en) rise_at = c;
        else fall_at = c;
      end
      prev = en;
      if (c == 15) en_sw = 1'b0;
    end
    checks++;
    if (changes !== 2 || rise_at !== 7 || fall_at !== 22) begin
      errors++;
      $display("FAIL en_timing: %0d changes rise %0d fall %0d, expected 2, 7, 22", changes, rise_at, fall_at);
    end
    idle(12);
  endtask

  task automatic test_reset_mid;
    int first = -1;
    int pulses = 0;
    int en_at = -1;
    en_sw = 1'b1;
    repeat (12) @(negedge clk);
    checks++;
    if (en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_pre_en: got %b expected 1", en);
    end
    start_btn = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({start, en, long_press} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: got %b expected 000", {start, en, long_press});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL reset_mid edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (en && en_at < 0) en_at = c;
    end
    checks++;
    if (pulses !== 1 || first !== 7 || en_at !== 7) begin
      errors++;
      $display("FAIL reset_mid_release: %0d pulses at %0d en at %0d, expected 1 at 7, en at 7", pulses, first, en_at);
    end
    idle(12);
  endtask

  task automatic test_long;
    int pulses = 0;
    int first = -1;
    int longs = 0;
    int long_at = -1;
    start_btn = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL long edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start) begin
        pulses++;
        if (first < 0) first = c;
      end
      if (long_press) begin
        longs++;
        if (long_at < 0) long_at = c;
      end
    end
    checks++;
    if (pulses !== 1 || first !== 7 || longs !== EXP_LONG || long_at !== EXP_LONG_AT) begin
      errors++;
      $display("FAIL long_press: start %0d at %0d long %0d at %0d, expected 1 at 7 long %0d at %0d",
               pulses, first, longs, long_at, EXP_LONG, EXP_LONG_AT);
    end
    idle(12);
  endtask

  task automatic test_simultaneous;
    int s_at = -1;
    int e_at = -1;
    start_btn = 1'b1;
    en_sw = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL simultaneous edge %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
      if (start && s_at < 0) s_at = c;
      if (en && e_at < 0) e_at = c;
    end
    checks++;
    if (s_at !== 7 || e_at !== 7) begin
      errors++;
      $display("FAIL simultaneous_align: start at %0d en at %0d, expected 7 and 7", s_at, e_at);
    end
    idle(12);
  endtask

  task automatic test_random;
    int t_s = 1;
    int t_e = 1;
    for (int c = 0; c < 600; c++) begin
      if (--t_s == 0) begin
        start_btn = ~start_btn;
        t_s = $urandom_range(1, 9);
      end
      if (--t_e == 0) begin
        en_sw = ~en_sw;
        t_e = $urandom_range(1, 9);
      end
      @(negedge clk);
      checks++;
      if ({start, en, long_press} !== {m_start, m_en, m_long}) begin
        errors++;
        $display("FAIL random cyc %0d: got %b expected %b", c, {start, en, long_press}, {m_start, m_en, m_long});
      end
    end
    idle(12);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_en();
    test_reset_mid();
    test_long();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
